phy_lane_pattern_gen: RTL and testbench

- Synthesizable, parametrised multi-lane traffic source for the PCIe PHY datapath.
- Replaces hand-coded lane stimulus with a programmable burst engine.
- Each burst is a COM (K28.5, 0xBC) sync preamble on all lanes, then a payload phase with per-lane data patterns, lane masking and hold (backpressure).
- Drives the lane inputs of the byte-striping/recirculation path; usable in benches and as on-chip BIST.

---
 rtl/phy_lane_pattern_gen.sv | 138 +++++++++++++
 tb/tb_phy_lane_pattern_gen.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_lane_pattern_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : phy_lane_pattern_gen                                         |
// | Purpose : Multi-lane burst source: COM sync preamble, then per-lane    |
// |           incrementing/decrementing payload with masking and hold.     |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module phy_lane_pattern_gen #(
   parameter int               LANES    = 4,
   parameter int               WIDTH    = 8,
   parameter logic [WIDTH-1:0] COM      = 8'hBC,
   parameter int               SYNC_LEN = 10,
   parameter int               DATA_LEN = 16,
   parameter logic [WIDTH-1:0] STEP     = 8'h11,
   parameter logic [WIDTH-1:0] SEED     = '0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   mode,
   input  logic [LANES-1:0]       lane_mask,
   input  logic                   hold,
   output logic [LANES*WIDTH-1:0] out_data,
   output logic [LANES-1:0]       out_valid,
   output logic                   busy,
   output logic                   done,
   output logic [15:0]            word_count
);

   localparam int               C_CNT_MAX   = (SYNC_LEN > DATA_LEN) ? SYNC_LEN : DATA_LEN;
   localparam int               C_CW        = $clog2(C_CNT_MAX + 1);
   localparam logic [C_CW-1:0]  C_SYNC_LAST = C_CW'(SYNC_LEN - 1);
   localparam logic [C_CW-1:0]  C_DATA_LAST = C_CW'(DATA_LEN - 1);
   localparam logic [WIDTH-1:0] C_INC_ADV   = WIDTH'(LANES);
   localparam logic [WIDTH-1:0] C_DEC_ADV   = WIDTH'(STEP * LANES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SYNC = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t                   r_state;
   logic [C_CW-1:0]          r_cnt;
   logic [WIDTH-1:0]         r_pat;
   logic                     r_mode;
   logic [LANES-1:0]         r_mask;

   logic [LANES-1:0]         w_mask_sel;
   logic [LANES*WIDTH-1:0]   w_sync_word;
   logic [LANES*WIDTH-1:0]   w_data_word;
   logic [WIDTH-1:0]         w_pat_next;

   // The first COM word is registered on the accepting edge, before r_mask is loaded.
   assign w_mask_sel = (r_state == ST_IDLE) ? lane_mask : r_mask;
   assign w_pat_next = r_mode ? (r_pat - C_DEC_ADV) : (r_pat + C_INC_ADV);

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      localparam logic [WIDTH-1:0] C_INC = WIDTH'(gi);
      localparam logic [WIDTH-1:0] C_DEC = WIDTH'(STEP * gi);
      logic [WIDTH-1:0] w_val;
      assign w_val = r_mode ? (r_pat - C_DEC) : (r_pat + C_INC);
      assign w_sync_word[gi*WIDTH +: WIDTH] = w_mask_sel[gi] ? COM : '0;
      assign w_data_word[gi*WIDTH +: WIDTH] = r_mask[gi] ? w_val : '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_pat      <= '0;
         r_mode     <= 1'b0;
         r_mask     <= '0;
         out_data   <= '0;
         out_valid  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         word_count <= '0;
      end else begin
         done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               out_data  <= '0;
               out_valid <= '0;
               busy      <= 1'b0;
               if (start) begin
                  r_state    <= ST_SYNC;
                  r_mode     <= mode;
                  r_mask     <= lane_mask;
                  r_cnt      <= '0;
                  r_pat      <= mode ? '1 : SEED;
                  word_count <= '0;
                  out_data   <= w_sync_word;
                  busy       <= 1'b1;
               end
            end
            ST_SYNC: begin
               out_valid <= '0;
               if (!hold) begin
                  if (r_cnt == C_SYNC_LAST) begin
                     r_state    <= ST_DATA;
                     r_cnt      <= '0;
                     out_data   <= w_data_word;
                     out_valid  <= r_mask;
                     r_pat      <= w_pat_next;
                     word_count <= word_count + 16'd1;
                  end else begin
                     r_cnt    <= r_cnt + 1'b1;
                     out_data <= w_sync_word;
                  end
               end
            end
            ST_DATA: begin
               // Held cycles keep the last word on the bus but flag it invalid.
               if (hold) begin
                  out_valid <= '0;
               end else if (r_cnt == C_DATA_LAST) begin
                  r_state   <= ST_IDLE;
                  r_cnt     <= '0;
                  out_data  <= '0;
                  out_valid <= '0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
               end else begin
                  r_cnt      <= r_cnt + 1'b1;
                  out_data   <= w_data_word;
                  out_valid  <= r_mask;
                  r_pat      <= w_pat_next;
                  word_count <= word_count + 16'd1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_phy_lane_pattern_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_phy_lane_pattern_gen                                      |
// | Purpose : Scoreboard bench for phy_lane_pattern_gen (4x8, sync 4/2).   |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_phy_lane_pattern_gen;

   localparam int SL = 4;
   localparam int DL = 2;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  valid;
      logic        busy;
      logic        done;
      logic [15:0] wc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        mode;
   logic [3:0]  lane_mask;
   logic        hold;

   logic [31:0] a_data,  b_data;
   logic [3:0]  a_valid, b_valid;
   logic        a_busy,  b_busy;
   logic        a_done,  b_done;
   logic [15:0] a_wc,    b_wc;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   phy_lane_pattern_gen #(
      .LANES(4), .WIDTH(8), .COM(8'hBC), .SYNC_LEN(SL), .DATA_LEN(DL),
      .STEP(8'h11), .SEED(8'h00)
   ) u_dut_a (
      .clk(clk), .reset(reset), .start(start), .mode(mode),
      .lane_mask(lane_mask), .hold(hold), .out_data(a_data),
      .out_valid(a_valid), .busy(a_busy), .done(a_done), .word_count(a_wc)
   );

   phy_lane_pattern_gen #(
      .LANES(4), .WIDTH(8), .COM(8'hBC), .SYNC_LEN(SL), .DATA_LEN(DL),
      .STEP(8'h11), .SEED(8'hFE)
   ) u_dut_b (
      .clk(clk), .reset(reset), .start(start), .mode(mode),
      .lane_mask(lane_mask), .hold(hold), .out_data(b_data),
      .out_valid(b_valid), .busy(b_busy), .done(b_done), .word_count(b_wc)
   );

   function automatic string fmt(exp_t x);
      return $sformatf("data=%h valid=%b busy=%b done=%b wc=%0d",
                       x.data, x.valid, x.busy, x.done, x.wc);
   endfunction

   function automatic logic [7:0] pat(bit m, logic [7:0] seed, int n);
      if (m) return 8'((255 - 17 * n) & 255);
      return 8'((int'(seed) + n) & 255);
   endfunction

   // Expected trace from the cycle after start is accepted through the done cycle.
   task automatic push_burst(input bit m, input logic [3:0] mask, input logic [7:0] seed,
                             input int hj, input int hlen);
      exp_t e;
      for (int s = 0; s < SL; s++) begin
         e = '0;
         for (int i = 0; i < 4; i++) if (mask[i]) e.data[i*8 +: 8] = 8'hBC;
         e.busy = 1'b1;
         q.push_back(e);
      end
      for (int j = 0; j < DL; j++) begin
         e = '0;
         for (int i = 0; i < 4; i++) if (mask[i]) e.data[i*8 +: 8] = pat(m, seed, j*4 + i);
         e.valid = mask;
         e.busy  = 1'b1;
         e.wc    = 16'(j + 1);
         q.push_back(e);
         if (j == hj) begin
            e.valid = '0;
            for (int h = 0; h < hlen; h++) q.push_back(e);
         end
      end
      e = '0;
      e.done = 1'b1;
      e.wc   = 16'(DL);
      q.push_back(e);
   endtask

   task automatic push_idle(input logic [15:0] wc);
      exp_t e;
      e = '0;
      e.wc = wc;
      q.push_back(e);
   endtask

   task automatic test_reset();
      exp_t o, e;
      reset = 1'b0; start = 1'b0; mode = 1'b0; hold = 1'b0; lane_mask = 4'h0;
      repeat (2) @(negedge clk);
      o = {a_data, a_valid, a_busy, a_done, a_wc};
      n_cmp++;
      if (o !== exp_t'('0)) begin
         n_bad++;
         $display("FAIL reset_state got %s want all zero", fmt(o));
      end
      reset = 1'b1;
      @(negedge clk);
      start = 1'b1; mode = 1'b1; lane_mask = 4'hF;
      push_burst(1'b1, 4'hF, 8'h00, -1, 0);
      for (int c = 0; c <= SL; c++) begin
         @(negedge clk);
         start = 1'b0;
         o = {a_data, a_valid, a_busy, a_done, a_wc};
         e = q.pop_front();
         n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL pre_reset cyc%0d got %s want %s", c, fmt(o), fmt(e));
         end
      end
      #2 reset = 1'b0;
      #1;
      o = {a_data, a_valid, a_busy, a_done, a_wc};
      n_cmp++;
      if (o !== exp_t'('0)) begin
         n_bad++;
         $display("FAIL async_reset got %s want all zero", fmt(o));
      end
      q.delete();
      @(negedge clk);
      o = {a_data, a_valid, a_busy, a_done, a_wc};
      n_cmp++;
      if (o !== exp_t'('0)) begin
         n_bad++;
         $display("FAIL reset_no_done got %s want all zero", fmt(o));
      end
      reset = 1'b1;
   endtask

   task automatic test_mode1();
      exp_t o, e;
      @(negedge clk);
      start = 1'b1; mode = 1'b1; lane_mask = 4'hF; hold = 1'b0;
      push_burst(1'b1, 4'hF, 8'h00, -1, 0);
      push_idle(16'(DL));
      for (int c = 0; c < SL + DL + 2; c++) begin
         @(negedge clk);
         start = 1'b0;
         o = {a_data, a_valid, a_busy, a_done, a_wc};
         e = q.pop_front();
         n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL mode1 cyc%0d got %s want %s", c, fmt(o), fmt(e));
         end
      end
   endtask

   task automatic test_mode0_mask();
      exp_t o, e;
      @(negedge clk);
      start = 1'b1; mode = 1'b0; lane_mask = 4'b0101; hold = 1'b0;
      push_burst(1'b0, 4'b0101, 8'h00, -1, 0);
      push_idle(16'(DL));
      for (int c = 0; c < SL + DL + 2; c++) begin
         @(negedge clk);
         start = 1'b0;
         // Changes after acceptance must not affect the running burst.
         mode = 1'b1; lane_mask = 4'hF;
         o = {a_data, a_valid, a_busy, a_done, a_wc};
         e = q.pop_front();
         n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL mode0_mask cyc%0d got %s want %s", c, fmt(o), fmt(e));
         end
      end
   endtask

   task automatic test_hold();
      exp_t o, e;
      @(negedge clk);
      start = 1'b1; mode = 1'b1; lane_mask = 4'hF; hold = 1'b0;
      push_burst(1'b1, 4'hF, 8'h00, 1, 3);
      push_idle(16'(DL));
      for (int c = 0; c < SL + DL + 3 + 2; c++) begin
         @(negedge clk);
         start = 1'b0;
         o = {a_data, a_valid, a_busy, a_done, a_wc};
         e = q.pop_front();
         n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL hold cyc%0d got %s want %s", c, fmt(o), fmt(e));
         end
         hold = (c >= SL + 1) && (c < SL + 4);
      end
      hold = 1'b0;
   endtask

   task automatic test_mask_zero();
      exp_t o, e;
      @(negedge clk);
      start = 1'b1; mode = 1'b0; lane_mask = 4'h0; hold = 1'b0;
      push_burst(1'b0, 4'h0, 8'h00, -1, 0);
      push_idle(16'(DL));
      for (int c = 0; c < SL + DL + 2; c++) begin
         @(negedge clk);
         start = 1'b0;
         o = {a_data, a_valid, a_busy, a_done, a_wc};
         e = q.pop_front();
         n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL mask_zero cyc%0d got %s want %s", c, fmt(o), fmt(e));
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t o, e;
      @(negedge clk);
      start = 1'b1; mode = 1'b0; lane_mask = 4'hF; hold = 1'b0;
      push_burst(1'b0, 4'hF, 8'h00, -1, 0);
      push_burst(1'b0, 4'hF, 8'h00, -1, 0);
      push_idle(16'(DL));
      for (int c = 0; c < 2 * (SL + DL + 1) + 1; c++) begin
         @(negedge clk);
         start = (c < SL + DL + 3);
         o = {a_data, a_valid, a_busy, a_done, a_wc};
         e = q.pop_front();
         n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL back_to_back cyc%0d got %s want %s", c, fmt(o), fmt(e));
         end
      end
      start = 1'b0;
   endtask

   task automatic test_wrap();
      exp_t o, e;
      @(negedge clk);
      start = 1'b1; mode = 1'b0; lane_mask = 4'hF; hold = 1'b0;
      push_burst(1'b0, 4'hF, 8'hFE, -1, 0);
      push_idle(16'(DL));
      for (int c = 0; c < SL + DL + 2; c++) begin
         @(negedge clk);
         start = 1'b0;
         o = {b_data, b_valid, b_busy, b_done, b_wc};
         e = q.pop_front();
         n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL wrap cyc%0d got %s want %s", c, fmt(o), fmt(e));
         end
      end
   endtask

   initial begin
      test_reset();
      test_mode1();
      test_mode0_mask();
      test_hold();
      test_mask_zero();
      test_back_to_back();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
